// File: rtl/afe_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : afe_spi_arbiter
// Description : Round-robin arbiter that shares one AFE SPI shift engine
//               between NREQ requesters. It issues one command per grant,
//               waits for the engine to finish and returns the 24-bit
//               readback to the requester that owned the transfer.
//               Optional watchdog: define AFE_SPI_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module afe_spi_arbiter #(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_cmd,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [23:0]          rsp_data,
    output logic                 rsp_error,
    output logic                 spi_strobe,
    output logic [31:0]          spi_cmd,
    input  logic [31:0]          spi_status,
    output logic [2:0]           grant,
    output logic                 active
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    // After reset requester 0 is the first one searched.
    localparam logic [2:0] c_GRANT_RST = 3'(NREQ - 1);
    localparam logic [3:0] c_NREQ4     = 4'(NREQ);

    // Elaboration-time parameter range checks.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("afe_spi_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("afe_spi_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [1:0]      r_state,      w_state_nxt;
    logic [2:0]      r_grant,      w_grant_nxt;
    logic [31:0]     r_spi_cmd,    w_spi_cmd_nxt;
    logic [NREQ-1:0] r_req_ack,    w_req_ack_nxt;
    logic [NREQ-1:0] r_rsp_valid,  w_rsp_valid_nxt;
    logic [23:0]     r_rsp_data,   w_rsp_data_nxt;
    logic            r_spi_strobe, w_spi_strobe_nxt;
    logic            r_active,     w_active_nxt;

    logic            w_busy;
    logic            w_timeout;
    logic [7:0]      w_req_pad;
    logic [3:0]      w_idx;
    logic [2:0]      w_winner;
    logic            w_found;
    logic [NREQ-1:0] w_win_onehot;
    logic [NREQ-1:0] w_grant_onehot;
    logic [31:0]     w_win_cmd;
    logic            w_unused_status;

    assign w_busy          = spi_status[31];
    assign w_req_pad       = 8'(req_valid);
    assign w_unused_status = ^spi_status[30:24];

    // Rotating search starting just after the last grant, wrapping at NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_idx    = 4'd0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = 4'(r_grant) + 4'(k);
            if (w_idx >= c_NREQ4) begin
                w_idx = w_idx - c_NREQ4;
            end
            if (!w_found && w_req_pad[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    // One-hot decode of winner/owner and selection of the winner's command.
    always_comb begin
        w_win_onehot   = '0;
        w_grant_onehot = '0;
        w_win_cmd      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_cmd       = req_cmd[32*i +: 32];
            end
            if (r_grant == 3'(i)) begin
                w_grant_onehot[i] = 1'b1;
            end
        end
    end

`ifdef AFE_SPI_ARB_WATCHDOG_EN
    localparam logic [15:0] c_TIMEOUT      = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] c_NOBUSY_LIMIT = 16'd7;

    logic [15:0] r_wdog, w_wdog_nxt;
    logic        r_rsp_error;

    // Watchdog: cleared at issue, counts while waiting on the engine.
    // A timeout only fires when the normal exit condition is not met.
    always_comb begin
        w_wdog_nxt = r_wdog;
        w_timeout  = 1'b0;
        case (r_state)
            c_ST_ISSUE: begin
                w_wdog_nxt = '0;
            end
            c_ST_WAIT_BUSY: begin
                w_wdog_nxt = r_wdog + 16'd1;
                w_timeout  = !w_busy && ((r_wdog >= c_TIMEOUT) || (r_wdog == c_NOBUSY_LIMIT));
            end
            c_ST_WAIT_DONE: begin
                w_wdog_nxt = r_wdog + 16'd1;
                w_timeout  = w_busy && (r_wdog >= c_TIMEOUT);
            end
            default: begin
                w_wdog_nxt = r_wdog;
            end
        endcase
    end

    // Watchdog counter and error flag; the flag is high only in the rsp cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog      <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_wdog      <= w_wdog_nxt;
            r_rsp_error <= w_timeout;
        end
    end

    assign rsp_error = r_rsp_error;
`else
    assign w_timeout = 1'b0;
    assign rsp_error = 1'b0;
`endif

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_spi_cmd_nxt    = r_spi_cmd;
        w_req_ack_nxt    = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_data_nxt   = r_rsp_data;
        w_spi_strobe_nxt = 1'b0;
        w_active_nxt     = r_active;
        case (r_state)
            c_ST_IDLE: begin
                w_active_nxt = 1'b0;
                // The busy gate also covers an engine left running by a reset.
                if (w_found && !w_busy) begin
                    w_grant_nxt      = w_winner;
                    w_spi_cmd_nxt    = w_win_cmd;
                    w_req_ack_nxt    = w_win_onehot;
                    w_spi_strobe_nxt = 1'b1;
                    w_active_nxt     = 1'b1;
                    w_state_nxt      = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (w_busy) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_rsp_valid_nxt = w_grant_onehot;
                    w_rsp_data_nxt  = '0;
                    w_state_nxt     = c_ST_IDLE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!w_busy) begin
                    w_rsp_valid_nxt = w_grant_onehot;
                    w_rsp_data_nxt  = spi_status[23:0];
                    w_state_nxt     = c_ST_IDLE;
                end else if (w_timeout) begin
                    w_rsp_valid_nxt = w_grant_onehot;
                    w_rsp_data_nxt  = '0;
                    w_state_nxt     = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= c_GRANT_RST;
            r_spi_cmd    <= '0;
            r_req_ack    <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_spi_strobe <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_spi_cmd    <= w_spi_cmd_nxt;
            r_req_ack    <= w_req_ack_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_spi_strobe <= w_spi_strobe_nxt;
            r_active     <= w_active_nxt;
        end
    end

    assign req_ack    = r_req_ack;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign spi_strobe = r_spi_strobe;
    assign spi_cmd    = r_spi_cmd;
    assign grant      = r_grant;
    assign active     = r_active;

endmodule
`default_nettype wire

// File: tb/tb_afe_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_afe_spi_arbiter
// Description : Self-checking bench for afe_spi_arbiter with a simple engine
//               model driving spi_status. Watchdog checks are compiled only
//               when AFE_SPI_ARB_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afe_spi_arbiter;

    localparam logic [31:0] c_CMD0 = 32'h8012_3456;
    localparam logic [31:0] c_CMD1 = 32'h0100_BEEF;
    localparam logic [31:0] c_CMD2 = 32'h8233_0011;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [95:0] req_cmd;
    logic [2:0]  req_ack;
    logic [2:0]  rsp_valid;
    logic [23:0] rsp_data;
    logic        rsp_error;
    logic        spi_strobe;
    logic [31:0] spi_cmd;
    logic [31:0] spi_status;
    logic [2:0]  grant;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;

    afe_spi_arbiter #(.NREQ(3), .TIMEOUT_CYCLES(65535)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_ack    (req_ack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error),
        .spi_strobe (spi_strobe),
        .spi_cmd    (spi_cmd),
        .spi_status (spi_status),
        .grant      (grant),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: on a strobe, busy for eng_len cycles, then readback
    // = command data XOR eng_mask. eng_hang suppresses busy entirely.
    int          eng_len  = 3;
    logic [23:0] eng_mask = 24'h0;
    bit          eng_hang = 1'b0;
    int          eng_cnt  = 0;
    logic [23:0] eng_cur  = 24'h0;
    int          strobe_busy_err = 0;

    initial begin
        spi_status = 32'h0;
        forever begin
            @(negedge clk);
            if (spi_strobe && spi_status[31]) strobe_busy_err++;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) spi_status = {8'h00, eng_cur};
            end else if (spi_strobe && !eng_hang) begin
                eng_cur    = spi_cmd[23:0] ^ eng_mask;
                eng_cnt    = eng_len;
                spi_status = 32'h8000_0000;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  rv;
        logic        drop;
        int          len;
        logic [23:0] mask;
        logic [2:0]  exp_ack;
        logic [2:0]  exp_grant;
        logic [31:0] exp_cmd;
        logic [23:0] exp_data;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic wait_ack(input string nm, output int cyc);
        cyc = 0;
        while (req_ack == 3'b000 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (req_ack == 3'b000) chk({nm, "_ack_wait"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string nm, output int cyc);
        cyc = 0;
        while (rsp_valid == 3'b000 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (rsp_valid == 3'b000) chk({nm, "_rsp_wait"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int cyc;
        bit stable;
        string nm;
        nm        = $sformatf("v%0d", id);
        req_valid = v.rv;
        eng_len   = v.len;
        eng_mask  = v.mask;
        wait_ack(nm, cyc);
        chk({nm, "_ack"},    32'(req_ack),    32'(v.exp_ack));
        chk({nm, "_strobe"}, 32'(spi_strobe), 32'd1);
        chk({nm, "_grant"},  32'(grant),      32'(v.exp_grant));
        chk({nm, "_cmd"},    spi_cmd,         v.exp_cmd);
        chk({nm, "_active"}, 32'(active),     32'd1);
        if (v.drop) req_valid = req_valid & ~req_ack;
        cyc    = 0;
        stable = 1'b1;
        while (rsp_valid == 3'b000 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (spi_cmd !== v.exp_cmd) stable = 1'b0;
        end
        chk({nm, "_cmd_stable"}, 32'(stable),    32'd1);
        chk({nm, "_latency"},    32'(cyc),       32'(v.len + 1));
        chk({nm, "_rsp_valid"},  32'(rsp_valid), 32'(v.exp_ack));
        chk({nm, "_rsp_data"},   32'(rsp_data),  32'(v.exp_data));
        chk({nm, "_rsp_error"},  32'(rsp_error), 32'd0);
        chk({nm, "_rsp_active"}, 32'(active),    32'd1);
    endtask

    initial begin
        int  cyc;
        int  ack2;
        bit  got_rsp;
        logic [23:0] got_data;

        vecs[0] = '{rv:3'b001, drop:1'b1, len:4, mask:24'hB791F3, exp_ack:3'b001, exp_grant:3'd0, exp_cmd:c_CMD0, exp_data:24'hA5A5A5};
        vecs[1] = '{rv:3'b111, drop:1'b0, len:3, mask:24'h0,      exp_ack:3'b010, exp_grant:3'd1, exp_cmd:c_CMD1, exp_data:24'h00BEEF};
        vecs[2] = '{rv:3'b111, drop:1'b0, len:3, mask:24'h0,      exp_ack:3'b100, exp_grant:3'd2, exp_cmd:c_CMD2, exp_data:24'h330011};
        vecs[3] = '{rv:3'b111, drop:1'b0, len:3, mask:24'h0,      exp_ack:3'b001, exp_grant:3'd0, exp_cmd:c_CMD0, exp_data:24'h123456};
        vecs[4] = '{rv:3'b111, drop:1'b0, len:3, mask:24'h0,      exp_ack:3'b010, exp_grant:3'd1, exp_cmd:c_CMD1, exp_data:24'h00BEEF};
        vecs[5] = '{rv:3'b111, drop:1'b0, len:3, mask:24'h0,      exp_ack:3'b100, exp_grant:3'd2, exp_cmd:c_CMD2, exp_data:24'h330011};
        vecs[6] = '{rv:3'b111, drop:1'b0, len:3, mask:24'h0,      exp_ack:3'b001, exp_grant:3'd0, exp_cmd:c_CMD0, exp_data:24'h123456};
        vecs[7] = '{rv:3'b100, drop:1'b1, len:2, mask:24'h0,      exp_ack:3'b100, exp_grant:3'd2, exp_cmd:c_CMD2, exp_data:24'h330011};
        vecs[8] = '{rv:3'b011, drop:1'b1, len:5, mask:24'h0,      exp_ack:3'b001, exp_grant:3'd0, exp_cmd:c_CMD0, exp_data:24'h123456};
        vecs[9] = '{rv:3'b010, drop:1'b1, len:2, mask:24'hFFFFFF, exp_ack:3'b010, exp_grant:3'd1, exp_cmd:c_CMD1, exp_data:24'hFF4110};

        rst       = 1'b1;
        req_valid = 3'b000;
        req_cmd   = {c_CMD2, c_CMD1, c_CMD0};
        repeat (3) @(negedge clk);

        chk("rst_req_ack",    32'(req_ack),    32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_error",  32'(rsp_error),  32'd0);
        chk("rst_spi_strobe", 32'(spi_strobe), 32'd0);
        chk("rst_active",     32'(active),     32'd0);
        chk("rst_rsp_data",   32'(rsp_data),   32'd0);
        chk("rst_spi_cmd",    spi_cmd,         32'd0);
        chk("rst_grant",      32'(grant),      32'd2);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) run_vec(v, vecs[v]);

        // active and rsp_valid drop the cycle after the response.
        @(negedge clk);
        chk("post_active",    32'(active),    32'd0);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);

        // Requester 2 pulses for one cycle while requester 0 is being served.
        eng_len   = 6;
        eng_mask  = 24'h0;
        req_valid = 3'b001;
        wait_ack("pulse", cyc);
        chk("pulse_ack", 32'(req_ack), 32'b001);
        req_valid = 3'b000;
        @(negedge clk);
        req_valid = 3'b100;
        @(negedge clk);
        req_valid = 3'b000;
        ack2     = 0;
        got_rsp  = 1'b0;
        got_data = 24'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ack[2]) ack2++;
            if (rsp_valid[0]) begin
                got_rsp  = 1'b1;
                got_data = rsp_data;
            end
        end
        chk("pulse_no_ack2",  32'(ack2),     32'd0);
        chk("pulse_rsp_seen", 32'(got_rsp),  32'd1);
        chk("pulse_rsp_data", 32'(got_data), 32'h123456);
        chk("pulse_grant",    32'(grant),    32'd0);

        // Reset in WAIT_DONE with the engine still busy.
        eng_len   = 20;
        req_valid = 3'b001;
        wait_ack("rstmid", cyc);
        chk("rstmid_ack", 32'(req_ack), 32'b001);
        req_valid = 3'b000;
        repeat (5) @(negedge clk);
        req_valid = 3'b010;
        eng_len   = 3;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req_ack",   32'(req_ack),    32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rstmid_strobe",    32'(spi_strobe), 32'd0);
        chk("rstmid_active",    32'(active),     32'd0);
        chk("rstmid_spi_cmd",   spi_cmd,         32'd0);
        chk("rstmid_rsp_data",  32'(rsp_data),   32'd0);
        chk("rstmid_grant",     32'(grant),      32'd2);
        cyc = 6;
        while (req_ack == 3'b000 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_ack1",      32'(req_ack), 32'b010);
        chk("rstmid_ack_delay", 32'(cyc),     32'd21);
        chk("rstmid_grant1",    32'(grant),   32'd1);
        chk("rstmid_cmd1",      spi_cmd,      c_CMD1);
        req_valid = 3'b000;
        wait_rsp("rstmid", cyc);
        chk("rstmid_rsp_valid1", 32'(rsp_valid), 32'b010);
        chk("rstmid_rsp_data1",  32'(rsp_data),  32'h00BEEF);

`ifdef AFE_SPI_ARB_WATCHDOG_EN
        // Engine never raises busy: watchdog completes with an error.
        @(negedge clk);
        eng_hang  = 1'b1;
        req_valid = 3'b001;
        wait_ack("wdog", cyc);
        chk("wdog_ack", 32'(req_ack), 32'b001);
        req_valid = 3'b000;
        wait_rsp("wdog", cyc);
        chk("wdog_rsp_valid", 32'(rsp_valid), 32'b001);
        chk("wdog_rsp_error", 32'(rsp_error), 32'd1);
        chk("wdog_rsp_data",  32'(rsp_data),  32'd0);
        eng_hang = 1'b0;
        @(negedge clk);
        chk("wdog_err_clear", 32'(rsp_error), 32'd0);
        eng_len   = 3;
        req_valid = 3'b010;
        wait_ack("wdog_resume", cyc);
        chk("wdog_resume_ack", 32'(req_ack), 32'b010);
        req_valid = 3'b000;
        wait_rsp("wdog_resume", cyc);
        chk("wdog_resume_err",  32'(rsp_error), 32'd0);
        chk("wdog_resume_data", 32'(rsp_data),  32'h00BEEF);
`endif

        repeat (3) @(negedge clk);
        chk("strobe_while_busy", 32'(strobe_busy_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/afe_spi_arbiter.md
Name: afe_spi_arbiter

Overview:
- Shares the single AFE SPI shift engine between NREQ independent requesters, e.g. the CPU CSR path, the AFE init sequencer and the periodic attenuator/readback updater.
- Arbitrates round-robin, issues one command word per grant and waits for the engine to finish.
- Returns the engine's 24-bit shift-register contents (the readback) to the requester that owned the transfer.
- Sits between the requesters and the engine's strobe/command/status ports.

Parameters:
- NREQ, 3: number of requesters, 2..8.
- TIMEOUT_CYCLES, 65535: watchdog limit in clk cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has a command pending.
- req_cmd  in  32*NREQ  requester i command in slice [32*i+:32].
  - bit31: 1 = 24-bit transfer, 0 = 16-bit transfer.
  - bits[24+:devsel]: chip-select index.
  - bits[23:0]: data, MSB-first.
- req_ack  out  NREQ  one-cycle pulse; command of requester i captured.
- rsp_valid  out  NREQ  one-cycle pulse; transfer for requester i complete.
- rsp_data  out  24  readback; valid while any rsp_valid bit is high.
- rsp_error  out  1  qualifies rsp_valid; transfer aborted by watchdog.
- spi_strobe  out  1  one-cycle start pulse to the engine.
- spi_cmd  out  32  command word to the engine; held stable from spi_strobe until completion.
- spi_status  in  32  engine status; bit31 = busy, bits[23:0] = shift register.
- grant  out  3  index of the current/last granted requester.
- active  out  1  high from the grant cycle until the rsp_valid cycle inclusive.

Behaviour:
- Reset values (all outputs registered):
  - req_ack, rsp_valid, rsp_error, spi_strobe, active = 0.
  - rsp_data, spi_cmd = 0.
  - grant = NREQ-1, so requester 0 has first priority.
  - state = IDLE.
- Reset mid-transfer: return to IDLE immediately. The engine is not reset, so the arbiter must stay in IDLE until spi_status[31]=0 before granting again.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE:
  - Grants only if |req_valid and spi_status[31]=0.
  - Winner is the first set bit searching grant+1, grant+2, ... modulo NREQ.
  - Same edge: spi_cmd <= req_cmd slice, grant <= winner, req_ack[winner] <= 1, active <= 1, state <= ISSUE.
- ISSUE:
  - spi_strobe=1 for exactly this cycle; req_ack is high this same cycle.
  - Next state: WAIT_BUSY.
- WAIT_BUSY: wait for spi_status[31]=1, normally the next cycle; then go to WAIT_DONE.
- WAIT_DONE:
  - On the first cycle with spi_status[31]=0: rsp_data <= spi_status[23:0], rsp_valid[grant] <= 1 for one cycle, rsp_error <= 0, state <= IDLE.
  - active drops the cycle after rsp_valid.
- Latency: the rsp_valid cycle is an IDLE cycle and may already grant the next request, as long as busy=0. Minimum request-to-request spacing is therefore engine time + 3 cycles.
- Requester rules:
  - Hold req_valid and req_cmd stable until req_ack.
  - Withdrawing req_valid before ack is legal; the request is dropped.
  - req_valid high in the cycle after ack is treated as a new request.
- Fairness: a requester that has just been served has lowest priority on the next arbitration. Simultaneous requests are served in rotating order.
- spi_cmd is never modified in ISSUE, WAIT_BUSY or WAIT_DONE.
- req_valid bits above NREQ do not exist. A grant register value >= NREQ cannot occur.

Optional Feature:
- Macro: AFE_SPI_ARB_WATCHDOG_EN.
- Enabled:
  - A 16-bit counter clears in ISSUE and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, or after 8 cycles in WAIT_BUSY without busy: rsp_valid[grant]=1, rsp_error=1, rsp_data=0, state <= IDLE.
  - The IDLE busy-gate still applies, so a hung engine blocks new grants.
- Disabled: no counter; waits indefinitely; rsp_error is tied 0.

Test Plan:
- Reset, then req_valid=3'b001 with cmd 0x8012_3456; engine model returns 0xA5A5A5 -> single req_ack[0], spi_strobe one cycle later, rsp_valid[0] with rsp_data=0xA5A5A5, rsp_error=0.
- req_valid=3'b111 held continuously, each requester with a distinct cmd -> grants in order 0,1,2,0,1,2. Each spi_cmd matches the granted slice, and no strobe occurs while busy=1.
- 16-bit cmd 0x0100_BEEF to chip-select 1 -> spi_cmd=0x0100_BEEF stable through the whole transfer; rsp_valid asserts exactly one cycle after busy falls.
- rst asserted mid-WAIT_DONE while the engine is still busy, with req_valid=3'b010 -> all outputs reset. No grant until busy=0; then grant=1.
- req_valid[2] pulsed for 1 cycle while the arbiter is busy with requester 0 -> requester 2 is never acked.
- AFE_SPI_ARB_WATCHDOG_EN, engine model never raises busy -> 8 cycles after strobe: rsp_valid[grant]=1, rsp_error=1, rsp_data=0, then normal grants resume.
